// File: rtl/m4_front_pkg.sv
// Shared types and reset constants for the LED-counter control front-end.
package m4_front_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HELD,
      REL
   } deb_state_t;

   localparam logic       FLAG_RST = 1'b1;
   localparam logic [3:0] D_RST    = 4'h0;

endpackage

// File: rtl/key_debounce.sv
// One raw key: 2-FF synchroniser followed by a four-state debouncer that
// accepts a level change only after DEB_CNT consecutive agreeing samples.
module key_debounce
   import m4_front_pkg::*;
#(
   parameter int unsigned DEB_CNT = 1000000
) (
   input  logic CP,
   input  logic CLR,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned     CW   = $clog2(DEB_CNT);
   // Entry into ARM/REL is the first agreeing sample, so the count is done
   // when it is about to step onto DEB_CNT-1.
   localparam logic [CW-1:0]   DONE = CW'(DEB_CNT - 2);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   deb_state_t    state;

   always_ff @(posedge CP or negedge CLR) begin
      if (!CLR) begin
         sync  <= '0;
         cnt   <= '0;
         state <= IDLE;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         press <= 1'b0;
         case (state)
            IDLE: begin
               if (sync[1]) begin
                  state <= ARM;
                  cnt   <= '0;
               end
            end
            ARM: begin
               if (!sync[1]) begin
                  state <= IDLE;
               end else if (cnt == DONE) begin
                  state <= HELD;
                  level <= 1'b1;
                  press <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HELD: begin
               if (!sync[1]) begin
                  state <= REL;
                  cnt   <= '0;
               end
            end
            REL: begin
               if (sync[1]) begin
                  state <= HELD;
               end else if (cnt == DONE) begin
                  state <= IDLE;
                  level <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/m4_key_front.sv
// Control front-end: debounced run/direction/load keys, synchronised switch
// bank and a run-gated prescaler producing EN/PE strobes for the counter.
module m4_key_front
   import m4_front_pkg::*;
#(
   parameter int unsigned DEB_CNT  = 1000000,
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       CP,
   input  logic       CLR,
   input  logic       KEY_RUN,
   input  logic       KEY_DIR,
   input  logic       KEY_LOAD,
   input  logic [3:0] SW,
   output logic       EN,
   output logic       PE,
   output logic       flag,
   output logic [3:0] D,
   output logic       RUN_LED
);

   localparam int unsigned   PW    = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TLAST = PW'(TICK_DIV - 1);

   logic [2:0]    press;   // [0] run, [1] dir, [2] load
   logic [2:0]    lvl;
   logic [3:0]    sw_m;
   logic [3:0]    sw_s;
   logic [PW-1:0] pre;

   key_debounce #(.DEB_CNT(DEB_CNT)) u_run (
      .CP(CP), .CLR(CLR), .raw(KEY_RUN),  .level(lvl[0]), .press(press[0])
   );
   key_debounce #(.DEB_CNT(DEB_CNT)) u_dir (
      .CP(CP), .CLR(CLR), .raw(KEY_DIR),  .level(lvl[1]), .press(press[1])
   );
   key_debounce #(.DEB_CNT(DEB_CNT)) u_load (
      .CP(CP), .CLR(CLR), .raw(KEY_LOAD), .level(lvl[2]), .press(press[2])
   );

   always_ff @(posedge CP or negedge CLR) begin
      if (!CLR) begin
         sw_m    <= '0;
         sw_s    <= '0;
         pre     <= '0;
         EN      <= 1'b0;
         PE      <= 1'b0;
         flag    <= FLAG_RST;
         D       <= D_RST;
         RUN_LED <= 1'b0;
      end else begin
         sw_m <= SW;
         sw_s <= sw_m;
         EN   <= 1'b0;
         PE   <= 1'b0;
         if (press[0]) RUN_LED <= ~RUN_LED;
         if (press[1]) flag    <= ~flag;
         // Load wins over a coincident tick; a pause request freezes the
         // prescaler in the same cycle so the tick is not emitted.
         if (press[2]) begin
            PE  <= 1'b1;
            D   <= sw_s;
            pre <= '0;
         end else if (RUN_LED && !press[0]) begin
            if (pre == TLAST) begin
               EN  <= 1'b1;
               pre <= '0;
            end else begin
               pre <= pre + PW'(1);
            end
         end
      end
   end

   // A press pulse always coincides with its debounced level being high,
   // and the two strobes never overlap.
   a_press_lvl : assert property (@(posedge CP) disable iff (!CLR) (press & ~lvl) == 3'b000);
   a_en_pe     : assert property (@(posedge CP) disable iff (!CLR) !(EN && PE));

endmodule

// File: tb/tb_m4_key_front.sv
// Bench for m4_key_front: directed vector table, hand sequences for bounce and
// async reset, and randomized keys checked against a streak-based model.
module tb_m4_key_front;

   localparam int DEB  = 4;
   localparam int TICK = 5;

   logic       CP = 1'b0;
   logic       CLR = 1'b1;
   logic       KEY_RUN = 1'b0;
   logic       KEY_DIR = 1'b0;
   logic       KEY_LOAD = 1'b0;
   logic [3:0] SW = 4'h0;
   logic       EN;
   logic       PE;
   logic       flag;
   logic [3:0] D;
   logic       RUN_LED;

   m4_key_front #(.DEB_CNT(DEB), .TICK_DIV(TICK)) dut (
      .CP(CP), .CLR(CLR), .KEY_RUN(KEY_RUN), .KEY_DIR(KEY_DIR),
      .KEY_LOAD(KEY_LOAD), .SW(SW), .EN(EN), .PE(PE), .flag(flag),
      .D(D), .RUN_LED(RUN_LED)
   );

   always #5 CP = ~CP;

   int checks = 0;
   int errors = 0;

   // reference model: raw history, agreeing-sample streaks, behaviour rules
   logic [2:0] rh1, rh2;
   logic [3:0] swh1, swh2;
   int         streak [3];
   logic [2:0] lvl, prs;
   int         pc;
   logic       m_run, m_flag, m_en, m_pe;
   logic [3:0] m_d;

   int   en_seen, pe_seen, led_chg;
   logic prev_led;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      rh1 = '0; rh2 = '0; swh1 = '0; swh2 = '0;
      lvl = '0; prs = '0; pc = 0;
      for (int i = 0; i < 3; i++) streak[i] = 0;
      m_run = 1'b0; m_flag = 1'b1; m_en = 1'b0; m_pe = 1'b0; m_d = 4'h0;
   endtask

   task automatic model_edge();
      logic [2:0] raw, syn, p;
      logic [3:0] sws;
      raw = {KEY_LOAD, KEY_DIR, KEY_RUN};
      syn = rh2;
      sws = swh2;
      p   = prs;
      m_en = 1'b0;
      m_pe = 1'b0;
      if (p[2]) begin
         m_pe = 1'b1;
         m_d  = sws;
         pc   = 0;
      end else if (m_run && !p[0]) begin
         pc = (pc + 1) % TICK;
         if (pc == 0) m_en = 1'b1;
      end
      if (p[0]) m_run  = !m_run;
      if (p[1]) m_flag = !m_flag;
      for (int i = 0; i < 3; i++) begin
         prs[i] = 1'b0;
         if (syn[i] != lvl[i]) begin
            streak[i]++;
            if (streak[i] == DEB) begin
               lvl[i]    = !lvl[i];
               streak[i] = 0;
               prs[i]    = lvl[i];
            end
         end else begin
            streak[i] = 0;
         end
      end
      rh2 = rh1; rh1 = raw;
      swh2 = swh1; swh1 = SW;
   endtask

   task automatic step();
      @(posedge CP);
      if (CLR) model_edge();
      else     model_reset();
      @(negedge CP);
      chk("model", int'({EN, PE, flag, D, RUN_LED}), int'({m_en, m_pe, m_flag, m_d, m_run}));
      if (EN) en_seen++;
      if (PE) pe_seen++;
      if (RUN_LED != prev_led) led_chg++;
      prev_led = RUN_LED;
   endtask

   task automatic chk_reset_now(input string nm);
      chk({nm, "_en"},   int'(EN),      0);
      chk({nm, "_pe"},   int'(PE),      0);
      chk({nm, "_flag"}, int'(flag),    1);
      chk({nm, "_d"},    int'(D),       0);
      chk({nm, "_run"},  int'(RUN_LED), 0);
   endtask

   typedef struct {
      logic       krun, kdir, kload;
      logic [3:0] sw;
      int         cyc;
      logic       e_run, e_flag;
      logic [3:0] e_d;
      int         e_en, e_pe;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic kr, input logic kd, input logic kl, input logic [3:0] s,
                      input int c, input logic er, input logic ef, input logic [3:0] ed,
                      input int een, input int epe);
      vec_t v;
      v.krun = kr; v.kdir = kd; v.kload = kl; v.sw = s; v.cyc = c;
      v.e_run = er; v.e_flag = ef; v.e_d = ed; v.e_en = een; v.e_pe = epe;
      tbl.push_back(v);
   endtask

   initial begin
      int waited;
      //   run dir load sw    cyc  RUN flag D     EN PE
      add(0, 0, 0, 4'h0, 50, 0, 1, 4'h0, 0, 0);   // idle after reset
      add(1, 0, 0, 4'h0,  6, 0, 1, 4'h0, 0, 0);   // one short of toggle
      add(1, 0, 0, 4'h0,  1, 1, 1, 4'h0, 0, 0);   // toggles on 7th
      add(0, 0, 0, 4'h0, 10, 1, 1, 4'h0, 2, 0);
      add(0, 0, 0, 4'h0, 15, 1, 1, 4'h0, 3, 0);
      add(0, 0, 0, 4'h0,  2, 1, 1, 4'h0, 0, 0);
      add(1, 0, 0, 4'h0,  7, 0, 1, 4'h0, 1, 0);   // pause at count 3
      add(0, 0, 0, 4'h0, 13, 0, 1, 4'h0, 0, 0);
      add(1, 0, 0, 4'h0,  7, 1, 1, 4'h0, 0, 0);   // resume
      add(0, 0, 0, 4'h0,  2, 1, 1, 4'h0, 1, 0);   // remaining count only
      add(0, 0, 0, 4'h0,  3, 1, 1, 4'h0, 0, 0);
      add(0, 0, 1, 4'hA,  7, 1, 1, 4'hA, 1, 1);   // load on a tick cycle
      add(0, 0, 0, 4'h3,  4, 1, 1, 4'hA, 0, 0);
      add(0, 0, 0, 4'h3,  1, 1, 1, 4'hA, 1, 0);   // EN 5 after PE
      add(0, 1, 0, 4'h3,  6, 1, 1, 4'hA, 1, 0);
      add(0, 1, 0, 4'h3,  1, 1, 0, 4'hA, 0, 0);   // flag falls
      add(0, 0, 0, 4'h3, 10, 1, 0, 4'hA, 2, 0);
      add(0, 1, 0, 4'h3,  7, 1, 1, 4'hA, 1, 0);   // flag back
      add(0, 0, 0, 4'h3,  8, 1, 1, 4'hA, 2, 0);

      prev_led = 1'b0;
      #2 CLR = 1'b0;
      model_reset();
      #1 chk_reset_now("init_rst");
      step();
      step();
      CLR = 1'b1;

      foreach (tbl[r]) begin
         KEY_RUN = tbl[r].krun; KEY_DIR = tbl[r].kdir; KEY_LOAD = tbl[r].kload; SW = tbl[r].sw;
         en_seen = 0; pe_seen = 0;
         repeat (tbl[r].cyc) step();
         chk($sformatf("row%0d_run", r),  int'(RUN_LED), int'(tbl[r].e_run));
         chk($sformatf("row%0d_flag", r), int'(flag),    int'(tbl[r].e_flag));
         chk($sformatf("row%0d_d", r),    int'(D),       int'(tbl[r].e_d));
         chk($sformatf("row%0d_en", r),   en_seen,       tbl[r].e_en);
         chk($sformatf("row%0d_pe", r),   pe_seen,       tbl[r].e_pe);
      end

      // bouncing press: 2-cycle runs never qualify, steady hold toggles once
      led_chg = 0;
      for (int i = 0; i < 20; i++) begin
         KEY_RUN = ((i % 4) < 2);
         step();
      end
      chk("bounce_press_chg", led_chg, 0);
      KEY_RUN = 1'b1;
      repeat (6) step();
      chk("bounce_before7", int'(RUN_LED), 1);
      step();
      chk("bounce_at7", int'(RUN_LED), 0);
      led_chg = 0;
      for (int i = 0; i < 20; i++) begin
         KEY_RUN = ((i % 4) >= 2);
         step();
      end
      KEY_RUN = 1'b0;
      repeat (15) step();
      chk("bounce_release_chg", led_chg, 0);

      // all three keys together, then asynchronous reset mid-run
      SW = 4'h5; KEY_RUN = 1'b1; KEY_DIR = 1'b1; KEY_LOAD = 1'b1;
      pe_seen = 0;
      repeat (7) step();
      KEY_RUN = 1'b0; KEY_DIR = 1'b0; KEY_LOAD = 1'b0;
      repeat (10) step();
      chk("multi_run",  int'(RUN_LED), 1);
      chk("multi_flag", int'(flag),    0);
      chk("multi_d",    int'(D),       5);
      chk("multi_pe",   pe_seen,       1);
      #2 CLR = 1'b0;
      model_reset();
      #1 chk_reset_now("mid_rst");
      step();
      CLR = 1'b1;
      KEY_RUN = 1'b1;
      repeat (7) step();
      KEY_RUN = 1'b0;
      chk("restart_run", int'(RUN_LED), 1);
      waited = 0;
      en_seen = 0;
      while (en_seen == 0 && waited < 20) begin
         step();
         waited++;
      end
      chk("restart_first_en", waited, 5);

      // randomized keys and switches
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) begin
            case ($urandom_range(2))
               0: KEY_RUN  = ~KEY_RUN;
               1: KEY_DIR  = ~KEY_DIR;
               default: KEY_LOAD = ~KEY_LOAD;
            endcase
         end
         if ($urandom_range(19) == 0) SW = 4'($urandom);
         if (i == 2000) begin
            #3 CLR = 1'b0;
            model_reset();
            #1 chk_reset_now("rand_rst");
            step();
            step();
            CLR = 1'b1;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
